// File: rtl/led_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_seq_pkg                                            |
// | Description : Shared types and helpers for the LED blink sequencer.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package led_seq_pkg;

  localparam int CNT_W_DEF     = 26;
  localparam int DWELL_W_DEF   = 8;
  localparam int NUM_STEPS_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_e;

  // LSB position of entry idx inside a flat table of width-bit entries
  function automatic int entry_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_seq_edge_det                                       |
// | Description : Registers the divider output and flags any change of  |
// |               level as a toggle, unless masked.                      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module led_seq_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic din,
  input  logic mask,
  output logic toggle
);

  logic din_q;

  // Track the previous divider level every cycle; the divider idles high
  always_ff @(posedge clock) begin
    if (reset) begin
      din_q <= 1'b1;
    end else begin
      din_q <= din;
    end
  end

  // Masking hides the forced-high transition caused by resetting the divider
  assign toggle = (din ^ din_q) & ~mask;

endmodule
`default_nettype wire

// File: rtl/led_blink_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : led_blink_sequencer                                    |
// | Description : Steps an LED clock divider through a table of blink    |
// |               periods, dwelling a set number of toggles per step.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module led_blink_sequencer
  import led_seq_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int NUM_STEPS = NUM_STEPS_DEF,
  parameter int DWELL_W   = DWELL_W_DEF,
  parameter int IDX_W     = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           pause,
  input  logic                           loop_en,
  input  logic [NUM_STEPS*CNT_W-1:0]     step_period,
  input  logic [NUM_STEPS*DWELL_W-1:0]   step_dwell,
  input  logic                           div_out,
  output logic                           div_enable,
  output logic                           div_reset,
  output logic [CNT_W-1:0]               div_count,
  output logic [IDX_W-1:0]               step_idx,
  output logic                           busy,
  output logic                           done
);

  seq_state_e           state;
  logic [DWELL_W-1:0]   toggle_cnt;
  logic [DWELL_W-1:0]   dwell_cur;
  logic                 ran_any;

  logic [CNT_W-1:0]     period_sel;
  logic [DWELL_W-1:0]   dwell_sel;
  logic [DWELL_W:0]     cnt_next;
  logic                 last_step;
  logic                 skip_step;
  logic                 step_end;
  logic                 toggle;
  logic                 arm_mask;

  assign arm_mask = (state == ST_ARM);

  led_seq_edge_det u_edge_det (
    .clock  (clock),
    .reset  (reset),
    .din    (div_out),
    .mask   (arm_mask),
    .toggle (toggle)
  );

  // Current table entry, step bookkeeping and end-of-step detection
  always_comb begin
    period_sel = step_period[entry_lsb(int'(step_idx), CNT_W) +: CNT_W];
    dwell_sel  = step_dwell[entry_lsb(int'(step_idx), DWELL_W) +: DWELL_W];
    cnt_next   = {1'b0, toggle_cnt} + 1'b1;
    last_step  = (step_idx == IDX_W'(NUM_STEPS - 1));
    skip_step  = (period_sel == '0) || (dwell_sel == '0);
    // A toggle counted while pausing can already complete the dwell, so a
    // full counter also ends the step once running resumes
    step_end   = (toggle_cnt >= dwell_cur) ||
                 (toggle && (cnt_next == {1'b0, dwell_cur}));
  end

  // Sequencer FSM with registered divider controls and status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      div_enable <= 1'b0;
      div_reset  <= 1'b1;
      div_count  <= '0;
      step_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      toggle_cnt <= '0;
      dwell_cur  <= '0;
      ran_any    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          div_enable <= 1'b0;
          div_reset  <= 1'b1;
          busy       <= 1'b0;
          if (start) begin
            state    <= ST_LOAD;
            step_idx <= '0;
            busy     <= 1'b1;
            ran_any  <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            div_enable <= 1'b0;
            div_reset  <= 1'b1;
            step_idx   <= '0;
          end else if (skip_step) begin
            if (!last_step) begin
              step_idx <= step_idx + IDX_W'(1);
            end else if (!loop_en) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else if (ran_any) begin
              step_idx <= '0;
              ran_any  <= 1'b0;
            end else begin
              // Looping over a table with nothing to run would spin forever
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            div_count  <= period_sel;
            dwell_cur  <= dwell_sel;
            div_reset  <= 1'b1;
            toggle_cnt <= '0;
            ran_any    <= 1'b1;
            state      <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            div_enable <= 1'b0;
            div_reset  <= 1'b1;
            step_idx   <= '0;
          end else begin
            div_reset  <= 1'b0;
            div_enable <= 1'b1;
            state      <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            div_enable <= 1'b0;
            div_reset  <= 1'b1;
            step_idx   <= '0;
          end else if (pause) begin
            state      <= ST_PAUSE;
            div_enable <= 1'b0;
            if (toggle) begin
              toggle_cnt <= cnt_next[DWELL_W-1:0];
            end
          end else if (step_end) begin
            div_enable <= 1'b0;
            div_reset  <= 1'b1;
            toggle_cnt <= '0;
            if (!last_step) begin
              step_idx <= step_idx + IDX_W'(1);
              state    <= ST_LOAD;
            end else if (loop_en) begin
              step_idx <= '0;
              ran_any  <= 1'b0;
              state    <= ST_LOAD;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end else if (toggle) begin
            toggle_cnt <= cnt_next[DWELL_W-1:0];
          end
        end

        ST_PAUSE: begin
          if (stop) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            div_enable <= 1'b0;
            div_reset  <= 1'b1;
            step_idx   <= '0;
          end else if (!pause) begin
            div_enable <= 1'b1;
            state      <= ST_RUN;
          end
        end

        ST_DONE: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          div_enable <= 1'b0;
          div_reset  <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          div_enable <= 1'b0;
          div_reset  <= 1'b1;
          step_idx   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
